// File: rtl/fifo_push_arb_pkg.sv
// Shared constants for the two-requester fifo push arbiter.
package fifo_push_arb_pkg;

  localparam int unsigned ARB_DW = 64;
  localparam int unsigned WAIT_W = 3;
  localparam int unsigned STAT_W = 8;

  localparam logic [WAIT_W-1:0] ARB_WAIT_MAX = 3'd7;

  // Requester indices, also the encoding of the round-robin pointer.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/fifo_push_arb_rr_wait_ctr.sv
// Per-requester saturating wait counter: counts cycles a request sits unacked.
module rr_wait_ctr
  import fifo_push_arb_pkg::*;
#(
  parameter logic [WAIT_W-1:0] WAIT_MAX = ARB_WAIT_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              ack,
  output logic [WAIT_W-1:0] cnt,
  output logic              at_max_c
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Clear on ack or dropped request, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (!req || ack) begin
      cnt_d = '0;
    end else if (cnt_q != WAIT_MAX) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_max_c = (cnt_q == WAIT_MAX);

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing the fifo push port between two producers.
// Optional per-requester ack counters: define FIFO_PUSH_ARB_STATS_EN.
module fifo_push_arb
  import fifo_push_arb_pkg::*;
#(
  parameter int unsigned       DW       = ARB_DW,
  parameter logic [WAIT_W-1:0] WAIT_MAX = ARB_WAIT_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  input  logic          fifo_full,
  input  logic          pop_fifo,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] data_in,
  output logic          data_in_valid,
  output logic          last_gnt,
  output logic          stall_err
`ifdef FIFO_PUSH_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] cnt0,
  output logic [STAT_W-1:0] cnt1
`endif
);

  logic accept_c;
  logic gnt0_c;
  logic gnt1_c;
  logic ack0_c;
  logic ack1_c;
  logic last_gnt_q;
  logic last_gnt_d;
  logic stall_err_q;
  logic stall_err_d;
  logic at_max0_c;
  logic at_max1_c;
  logic [WAIT_W-1:0] wait0;
  logic [WAIT_W-1:0] wait1;

  // A full fifo that is popping this cycle still has room for one push.
  assign accept_c = ~fifo_full | pop_fifo;

  // Zero-latency grant; ties go to the requester not served last.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (req0 && req1) begin
      if (last_gnt_q == REQ1) begin
        gnt0_c = 1'b1;
      end else begin
        gnt1_c = 1'b1;
      end
    end else begin
      gnt0_c = req0;
      gnt1_c = req1;
    end
  end

  // Handshake outputs are forced quiet while reset is asserted.
  assign ack0_c        = gnt0_c & accept_c & ~rst;
  assign ack1_c        = gnt1_c & accept_c & ~rst;
  assign ack0          = ack0_c;
  assign ack1          = ack1_c;
  assign data_in_valid = (req0 | req1) & accept_c & ~rst;
  assign data_in       = gnt1_c ? data1 : data0;

  rr_wait_ctr #(.WAIT_MAX(WAIT_MAX)) u_wait0 (
    .clk      (clk),
    .rst      (rst),
    .req      (req0),
    .ack      (ack0_c),
    .cnt      (wait0),
    .at_max_c (at_max0_c)
  );

  rr_wait_ctr #(.WAIT_MAX(WAIT_MAX)) u_wait1 (
    .clk      (clk),
    .rst      (rst),
    .req      (req1),
    .ack      (ack1_c),
    .cnt      (wait1),
    .at_max_c (at_max1_c)
  );

  // Pointer moves only on an actual transfer so fairness survives stalls.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (ack1_c) begin
      last_gnt_d = REQ1;
    end else if (ack0_c) begin
      last_gnt_d = REQ0;
    end
    stall_err_d = stall_err_q | at_max0_c | at_max1_c;
  end

  // Pointer and sticky timeout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q  <= REQ1;
      stall_err_q <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign last_gnt  = last_gnt_q;
  assign stall_err = stall_err_q;

`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_q;
  logic [STAT_W-1:0] cnt0_d;
  logic [STAT_W-1:0] cnt1_q;
  logic [STAT_W-1:0] cnt1_d;

  // Ack counters wrap naturally at their width.
  always_comb begin
    cnt0_d = ack0_c ? cnt0_q + STAT_W'(1) : cnt0_q;
    cnt1_d = ack1_c ? cnt1_q + STAT_W'(1) : cnt1_q;
  end

  // Ack counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

  logic unused_wait;
  assign unused_wait = ^{wait0, wait1};
`else
  logic unused_wait;
  assign unused_wait = ^{wait0, wait1};
`endif

endmodule
